// File: rtl/hex_display_scanner.sv
// N-digit hex display driver: latched value, static and scanned active-low 7-segment views,
// leading-zero blanking, per-digit decimal points and per-digit blinking.
module hex_display_scanner #(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blink_en,
    input  logic                    blank_lz,
    output logic [7*NUM_DIGITS-1:0] seg_all_n,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_tick
);

    localparam int SLOT_W  = $clog2(SCAN_DIV);
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [4*NUM_DIGITS-1:0] data_q;
    logic [NUM_DIGITS-1:0]   dp_q;
    logic [NUM_DIGITS-1:0]   blink_q;

    logic [SLOT_W-1:0]  slot_cnt;
    logic [IDX_W-1:0]   digit_idx;
    logic [FRAME_W-1:0] frame_cnt;
    logic               blink_phase;

    logic [NUM_DIGITS-1:0] upper_zero;
    logic [NUM_DIGITS-1:0] digit_off;
    logic [6:0]            cur_seg;
    logic                  cur_dp;
    logic                  slot_wrap;
    logic                  idx_wrap;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    // upper_zero[i] is set when nibbles i..NUM_DIGITS-1 are all zero.
    always_comb begin
        logic run;
        // NOTE: every variable gets a value before any conditional use, so no latch is inferred.
        run        = 1'b1;
        upper_zero = '0;
        digit_off  = '0;
        seg_all_n  = '1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run           = run && (data_q[4*i +: 4] == 4'h0);
            upper_zero[i] = run;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digit_off[i] = (blank_lz && (i != 0) && upper_zero[i]) || (blink_q[i] && blink_phase);
            seg_all_n[7*i +: 7] = digit_off[i] ? 7'h7F : hex_to_seg(data_q[4*i +: 4]);
        end
    end

    assign cur_seg   = seg_all_n[7*digit_idx +: 7];
    assign cur_dp    = dp_q[digit_idx] && !digit_off[digit_idx];
    assign slot_wrap = (slot_cnt == SLOT_W'(SCAN_DIV - 1));
    assign idx_wrap  = (digit_idx == IDX_W'(NUM_DIGITS - 1));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            data_q  <= '0;
            dp_q    <= '0;
            blink_q <= '0;
        end else if (load) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            data_q  <= data_in;
            dp_q    <= dp_in;
            blink_q <= blink_en;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            slot_cnt    <= '0;
            digit_idx   <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            seg_n       <= 7'h7F;
            dp_n        <= 1'b1;
            an_n        <= '1;
            frame_tick  <= 1'b0;
        end else begin
            frame_tick <= slot_wrap && idx_wrap;
            if (slot_wrap) begin
                slot_cnt <= '0;
                if (idx_wrap) begin
                    digit_idx <= '0;
                    if (frame_cnt == FRAME_W'(BLINK_FRAMES - 1)) begin
                        frame_cnt   <= '0;
                        blink_phase <= ~blink_phase;
                    end else begin
                        frame_cnt <= frame_cnt + 1'b1;
                    end
                end else begin
                    digit_idx <= digit_idx + 1'b1;
                end
            end else begin
                slot_cnt <= slot_cnt + 1'b1;
            end
            // Anode and segments load on the same edge so the display never ghosts.
            seg_n <= cur_seg;
            dp_n  <= ~cur_dp;
            an_n  <= ~(NUM_DIGITS'(1) << digit_idx);
        end
    end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Randomised and directed bench for hex_display_scanner, checked against a cycle-count based model.
module tb_hex_display_scanner;

    localparam int N     = 4;
    localparam int S     = 4;
    localparam int BF    = 2;
    localparam int FRAME = N * S;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] data_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blink_en = '0;
    logic        blank_lz = 1'b0;
    logic [27:0] seg_all_n;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;
    logic        frame_tick;

    hex_display_scanner #(.NUM_DIGITS(N), .SCAN_DIV(S), .BLINK_FRAMES(BF)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .load(load), .data_in(data_in), .dp_in(dp_in),
        .blink_en(blink_en), .blank_lz(blank_lz), .seg_all_n(seg_all_n), .seg_n(seg_n),
        .dp_n(dp_n), .an_n(an_n), .frame_tick(frame_tick)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Model: latched registers plus t = clock edges since reset release.
    logic [15:0] m_data;
    logic [3:0]  m_dp, m_blink;
    int          t;
    logic [6:0]  e_seg;
    logic        e_dp, e_tick;
    logic [3:0]  e_an;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0d: got %h expected %h", name, t, act, exp);
        end
    endtask

    function automatic int phase_now();
        return (t / (FRAME * BF)) % 2;
    endfunction

    function automatic logic off(input int i, input logic lz);
        return (lz && i > 0 && (m_data >> (4 * i)) == 16'h0) || (m_blink[i] && phase_now() == 1);
    endfunction

    function automatic logic [6:0] dig_code(input int i, input logic lz);
        return off(i, lz) ? 7'h7F : seg_tab[m_data[4*i +: 4]];
    endfunction

    function automatic logic [27:0] static_view(input logic lz);
        logic [27:0] v;
        v = '1;
        for (int i = 0; i < N; i++) v[7*i +: 7] = dig_code(i, lz);
        return v;
    endfunction

    task automatic model_reset();
        m_data  = '0;
        m_dp    = '0;
        m_blink = '0;
        t       = 0;
        e_seg   = 7'h7F;
        e_dp    = 1'b1;
        e_an    = 4'hF;
        e_tick  = 1'b0;
    endtask

    task automatic compare_all();
        check("seg_all_n", 32'(seg_all_n), 32'(static_view(blank_lz)));
        check("seg_n", 32'(seg_n), 32'(e_seg));
        check("dp_n", 32'(dp_n), 32'(e_dp));
        check("an_n", 32'(an_n), 32'(e_an));
        check("frame_tick", 32'(frame_tick), 32'(e_tick));
    endtask

    // Inputs are already driven; predict the coming edge, then check at the next falling edge.
    task automatic step();
        int idx;
        idx    = (t / S) % N;
        e_seg  = dig_code(idx, blank_lz);
        e_dp   = ~(m_dp[idx] && !off(idx, blank_lz));
        e_an   = ~(4'b0001 << idx);
        e_tick = ((t + 1) % FRAME) == 0;
        if (load) begin
            m_data  = data_in;
            m_dp    = dp_in;
            m_blink = blink_en;
        end
        t++;
        @(negedge Clk);
        compare_all();
    endtask

    task automatic load_step(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
        data_in  = d;
        dp_in    = dp;
        blink_en = bl;
        load     = 1'b1;
        step();
        load     = 1'b0;
    endtask

    logic [6:0] lit_seg [4] = '{7'h0E, 7'h30, 7'h08, 7'h79};
    logic [3:0] lit_an  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

    initial begin
        model_reset();
        repeat (2) @(negedge Clk);
        compare_all();
        check("reset_an", 32'(an_n), 32'h0000_000F);
        Reset_n = 1'b1;
        step();
        check("release_an", 32'(an_n), 32'h0000_000E);
        repeat (10) step();

        // Mid-scan asynchronous reset.
        #2 Reset_n = 1'b0;
        #1;
        check("async_an", 32'(an_n), 32'h0000_000F);
        check("async_seg", 32'(seg_n), 32'h0000_007F);
        check("async_dp", 32'(dp_n), 32'h1);
        check("async_tick", 32'(frame_tick), 32'h0);
        model_reset();
        @(negedge Clk);
        compare_all();
        Reset_n = 1'b1;
        step();
        check("restart_an", 32'(an_n), 32'h0000_000E);

        // Static and scanned views of 1A3F.
        blank_lz = 1'b0;
        load_step(16'h1A3F, 4'h0, 4'h0);
        check("static_1A3F", 32'(seg_all_n), 32'({7'h79, 7'h08, 7'h30, 7'h0E}));
        while (t % FRAME != 0) step();
        for (int d = 0; d < N; d++) begin
            for (int k = 0; k < S; k++) begin
                step();
                check("scan_an", 32'(an_n), 32'(lit_an[d]));
                check("scan_seg", 32'(seg_n), 32'(lit_seg[d]));
            end
        end

        // Leading-zero blanking.
        blank_lz = 1'b1;
        load_step(16'h0050, 4'h0, 4'h0);
        check("lz_0050", 32'(seg_all_n), 32'({7'h7F, 7'h7F, 7'h12, 7'h40}));
        repeat (FRAME) step();
        load_step(16'h0000, 4'h0, 4'h0);
        check("lz_0000", 32'(seg_all_n), 32'({7'h7F, 7'h7F, 7'h7F, 7'h40}));
        repeat (FRAME) step();

        // Blink and decimal point on digit 1.
        blank_lz = 1'b0;
        load_step(16'h1234, 4'b0010, 4'b0010);
        while (t % (2 * FRAME * BF) != 0) step();
        for (int s = 1; s <= 2 * FRAME * BF; s++) begin
            step();
            if (s == 6) begin
                check("blink_on_seg", 32'(seg_n), 32'h30);
                check("blink_on_dp", 32'(dp_n), 32'h0);
                check("blink_on_an", 32'(an_n), 32'hD);
            end
            if (s == 38) begin
                check("blink_off_seg", 32'(seg_n), 32'h7F);
                check("blink_off_dp", 32'(dp_n), 32'h1);
                check("blink_off_an", 32'(an_n), 32'hD);
            end
            if (s % FRAME == 0) check("tick_lit", 32'(frame_tick), 32'h1);
        end

        // Load coinciding with a slot wrap.
        load_step(16'h0001, 4'h0, 4'h0);
        while ((t + 1) % S != 0) step();
        load_step(16'hFFFF, 4'h0, 4'h0);
        step();
        check("wrap_load_seg", 32'(seg_n), 32'h0E);

        // Every nibble value on every digit.
        for (int d = 0; d < N; d++) begin
            for (int v = 0; v < 16; v++) begin
                logic [15:0] val;
                val = 16'($urandom);
                val[4*d +: 4] = 4'(v);
                load_step(val, 4'($urandom), 4'h0);
                check("sweep_static", 32'(seg_all_n[7*d +: 7]), 32'(seg_tab[v]));
                repeat (FRAME - 1) step();
            end
        end

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            load = ($urandom % 6) == 0;
            if (load) begin
                data_in  = 16'($urandom);
                if (($urandom % 3) == 0) data_in = data_in & 16'h00FF;
                if (($urandom % 5) == 0) data_in = 16'h0;
                dp_in    = 4'($urandom);
                blink_en = 4'($urandom);
            end
            if (($urandom % 16) == 0) blank_lz = ~blank_lz;
            step();
        end
        load = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
